// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order ROB with CDB writeback, head commit and bypassed operand lookup
module reorder_buffer #(
  parameter int DEPTH  = 15,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              alloc_valid,
  input  logic [REG_W-1:0]  alloc_dest,
  output logic              alloc_ready,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic [TAG_W-1:0]  qj_tag,
  input  logic [TAG_W-1:0]  qk_tag,
  output logic              qj_ready,
  output logic              qk_ready,
  output logic [DATA_W-1:0] qj_data,
  output logic [DATA_W-1:0] qk_data,
  output logic              commit_valid,
  output logic [TAG_W-1:0]  commit_tag,
  output logic [REG_W-1:0]  commit_dest,
  output logic [DATA_W-1:0] commit_data
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  logic [TAG_W-1:0]  head, tail, head_nx, tail_nx, wb_slot;
  logic [CNT_W-1:0]  count;
  logic [DEPTH-1:0]  busy, rdy;
  logic [REG_W-1:0]  dest [DEPTH];
  logic [DATA_W-1:0] data [DEPTH];
  logic              alloc_fire, commit_fire, wb_fire;
  function automatic logic [DATA_W:0] look(input logic [TAG_W-1:0] t);
    logic [TAG_W-1:0] s;
    s = t - 1'b1;
    if (t != '0 && t <= TAG_W'(DEPTH) && busy[s] && rdy[s]) return {1'b1, data[s]};
    if (t != '0 && cdb_valid && cdb_tag == t) return {1'b1, cdb_data};
    return '0;
  endfunction
  always_comb begin
    alloc_ready = count < CNT_W'(DEPTH);
    alloc_tag   = tail + 1'b1;
    alloc_fire  = alloc_valid && alloc_ready;
    commit_fire = busy[head] && rdy[head];
    wb_slot     = cdb_tag - 1'b1;
    wb_fire     = cdb_valid && cdb_tag != '0 && cdb_tag <= TAG_W'(DEPTH) && busy[wb_slot];
    head_nx     = head == TAG_W'(DEPTH - 1) ? '0 : head + 1'b1;
    tail_nx     = tail == TAG_W'(DEPTH - 1) ? '0 : tail + 1'b1;
    {qj_ready, qj_data} = look(qj_tag);
    {qk_ready, qk_data} = look(qk_tag);
  end
  // commit clears after writeback so a late CDB hit on the retiring head cannot resurrect it
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      busy         <= '0;
      rdy          <= '0;
      commit_valid <= 1'b0;
      if (!rst) begin
        commit_tag  <= '0;
        commit_dest <= '0;
        commit_data <= '0;
      end
    end else begin
      if (wb_fire) begin
        rdy[wb_slot]  <= 1'b1;
        data[wb_slot] <= cdb_data;
      end
      commit_valid <= commit_fire;
      if (commit_fire) begin
        commit_tag  <= head + 1'b1;
        commit_dest <= dest[head];
        commit_data <= data[head];
        busy[head]  <= 1'b0;
        rdy[head]   <= 1'b0;
        head        <= head_nx;
      end
      if (alloc_fire) begin
        busy[tail] <= 1'b1;
        rdy[tail]  <= 1'b0;
        dest[tail] <= alloc_dest;
        tail       <= tail_nx;
      end
      count <= count + CNT_W'(alloc_fire) - CNT_W'(commit_fire);
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed and random stimulus against a program-order queue model of the ROB
module tb_reorder_buffer;
  logic        clk = 1'b0;
  logic        rst, flush, alloc_valid, cdb_valid;
  logic [4:0]  alloc_dest;
  logic [3:0]  cdb_tag, qj_tag, qk_tag, alloc_tag, commit_tag;
  logic [31:0] cdb_data, qj_data, qk_data, commit_data;
  logic        alloc_ready, qj_ready, qk_ready, commit_valid;
  logic [4:0]  commit_dest;
  int          errors = 0;
  int          checks = 0;
  int          q[$];
  logic        m_rdy [16];
  logic [4:0]  m_dest [16];
  logic [31:0] m_data [16];
  int          next_tag = 1;
  logic        e_cv = 1'b0;
  logic        e_known = 1'b0;
  int          e_ct = 0;
  logic [4:0]  e_cd = '0;
  logic [31:0] e_cdat = '0;

  reorder_buffer dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_dest(alloc_dest), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .qj_tag(qj_tag), .qk_tag(qk_tag), .qj_ready(qj_ready), .qk_ready(qk_ready),
    .qj_data(qj_data), .qk_data(qk_data),
    .commit_valid(commit_valid), .commit_tag(commit_tag), .commit_dest(commit_dest), .commit_data(commit_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic in_q(input int t);
    foreach (q[i]) if (q[i] == t) return 1'b1;
    return 1'b0;
  endfunction

  // An entry is visible once written back; otherwise a same-cycle broadcast to the tag is forwarded
  function automatic logic [32:0] model_look(input int t);
    if (t != 0 && in_q(t) && m_rdy[t]) return {1'b1, m_data[t]};
    if (t != 0 && cdb_valid && int'(cdb_tag) == t) return {1'b1, cdb_data};
    return 33'd0;
  endfunction

  task automatic model_edge();
    logic full, c;
    int   ct;
    full = q.size() >= 15;
    if (!rst || flush) begin
      q.delete();
      next_tag = 1;
      e_cv = 1'b0;
      foreach (m_rdy[i]) m_rdy[i] = 1'b0;
      if (!rst) begin
        e_known = 1'b1;
        e_ct = 0;
        e_cd = '0;
        e_cdat = '0;
      end
      return;
    end
    c = q.size() > 0 && m_rdy[q[0]];
    if (c) begin
      e_ct = q[0];
      e_cd = m_dest[q[0]];
      e_cdat = m_data[q[0]];
      e_known = 1'b1;
    end
    ct = int'(cdb_tag);
    if (cdb_valid && ct >= 1 && ct <= 15 && in_q(ct)) begin
      m_rdy[ct] = 1'b1;
      m_data[ct] = cdb_data;
    end
    if (c) begin
      m_rdy[q[0]] = 1'b0;
      void'(q.pop_front());
    end
    e_cv = c;
    if (alloc_valid && !full) begin
      q.push_back(next_tag);
      m_rdy[next_tag] = 1'b0;
      m_dest[next_tag] = alloc_dest;
      next_tag = next_tag == 15 ? 1 : next_tag + 1;
    end
  endtask

  task automatic tick();
    logic [32:0] lj, lk;
    #1;
    lj = model_look(int'(qj_tag));
    lk = model_look(int'(qk_tag));
    chk("alloc_ready", 32'(alloc_ready), 32'(q.size() < 15));
    chk("alloc_tag", 32'(alloc_tag), 32'(next_tag));
    chk("qj_ready", 32'(qj_ready), 32'(lj[32]));
    chk("qj_data", qj_data, lj[31:0]);
    chk("qk_ready", 32'(qk_ready), 32'(lk[32]));
    chk("qk_data", qk_data, lk[31:0]);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("commit_valid", 32'(commit_valid), 32'(e_cv));
    if (e_known) begin
      chk("commit_tag", 32'(commit_tag), 32'(e_ct));
      chk("commit_dest", 32'(commit_dest), 32'(e_cd));
      chk("commit_data", commit_data, e_cdat);
    end
  endtask

  task automatic drv(input logic r, input logic f, input logic av, input logic [4:0] ad,
                     input logic cv, input logic [3:0] ct, input logic [31:0] cd,
                     input logic [3:0] jt, input logic [3:0] kt);
    rst = r; flush = f; alloc_valid = av; alloc_dest = ad;
    cdb_valid = cv; cdb_tag = ct; cdb_data = cd; qj_tag = jt; qk_tag = kt;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv(1, 0, 0, 0, 0, 0, 0, 1, 2);
  endtask

  initial begin
    int  pick;
    logic [3:0] ct;
    rst = 0; flush = 0; alloc_valid = 0; alloc_dest = 0;
    cdb_valid = 0; cdb_tag = 0; cdb_data = 0; qj_tag = 0; qk_tag = 0;
    @(negedge clk);
    // reset held for two cycles
    drv(0, 0, 1, 7, 1, 1, 32'h1234, 1, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // single alloc, writeback and commit
    drv(1, 0, 1, 3, 0, 0, 0, 1, 0);
    drv(1, 0, 0, 0, 1, 1, 32'hDEADBEEF, 1, 2);
    idle(2);
    // fill, overflow attempt, wrap-around
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) drv(1, 0, 1, 5'(i + 10), 0, 0, 0, 4'(i + 1), 1);
    drv(1, 0, 1, 31, 0, 0, 0, 15, 1);
    drv(1, 0, 0, 0, 1, 1, 32'hA5A5_0001, 1, 15);
    drv(1, 0, 0, 0, 0, 0, 0, 1, 2);
    drv(1, 0, 1, 9, 0, 0, 0, 2, 1);
    drv(1, 0, 0, 0, 0, 0, 0, 1, 2);
    drv(1, 1, 0, 0, 0, 0, 0, 1, 2);
    // out-of-order completion
    drv(1, 0, 1, 4, 0, 0, 0, 1, 2);
    drv(1, 0, 1, 6, 0, 0, 0, 1, 2);
    drv(1, 0, 0, 0, 1, 2, 32'h2222, 1, 2);
    drv(1, 0, 0, 0, 1, 1, 32'h1111, 1, 2);
    idle(3);
    // lookup bypass and ignored writeback to a free slot
    drv(1, 0, 1, 8, 0, 0, 0, 3, 4);
    drv(1, 0, 1, 9, 0, 0, 0, 3, 4);
    drv(1, 0, 0, 0, 1, 4, 32'h55, 4, 3);
    drv(1, 0, 0, 0, 1, 9, 32'h99, 4, 3);
    drv(1, 0, 0, 0, 0, 0, 0, 9, 4);
    // flush and reset in mid-fill
    for (int i = 0; i < 5; i++) drv(1, 0, 1, 5'(i), 0, 0, 0, 1, 2);
    drv(1, 1, 1, 1, 1, 6, 32'h77, 6, 7);
    idle(2);
    for (int i = 0; i < 3; i++) drv(1, 0, 1, 5'(i + 20), 0, 0, 0, 1, 2);
    drv(0, 0, 1, 2, 1, 1, 32'h88, 1, 2);
    idle(2);
    // random traffic
    for (int n = 0; n < 800; n++) begin
      pick = int'($urandom_range(0, 99));
      ct = (q.size() > 0 && pick < 70) ? 4'(q[$urandom_range(0, q.size() - 1)]) : 4'($urandom_range(0, 15));
      drv($urandom_range(0, 99) != 0, $urandom_range(0, 59) == 0, $urandom_range(0, 9) < 6, 5'($urandom),
          $urandom_range(0, 9) < 7, ct, $urandom,
          (pick % 3 == 0) ? ct : 4'($urandom_range(1, 15)), 4'($urandom_range(1, 15)));
    end
    idle(20);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
